// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, optional wait states,
// lane-masked stores and sign/zero-extended loads. `DMEM_ERR_LATCH_EN adds a first-fault latch.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_dmtype,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_ERR_LATCH_EN
  ,
  output logic        err_sticky,
  output logic [31:0] err_addr
`endif
);

  // state | meaning
  // IDLE  | ready for a request
  // WAIT  | request captured, counting down wait states
  // RESP  | one-cycle response pulse; commit happened on entry
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int AW = $clog2(DEPTH);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [2:0]  cap_dmtype;

  logic        accept;
  logic        commit;
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [2:0]  cur_dmtype;
  logic [AW-1:0] word_idx;
  logic [1:0]  byte_off;
  logic        misaligned;
  logic        out_of_range;
  logic        bad_type;
  logic        fault;
  logic [31:0] mem_word;
  logic [31:0] lane_data;
  logic [31:0] load_data;
  logic [31:0] store_data;
  logic [31:0] store_word;
  logic [3:0]  lane_en;

  logic [31:0] mem [DEPTH];

  assign accept = (state == IDLE) && req_valid;
  // With no wait states the accept edge is also the commit edge, so use the live request.
  assign commit = rst && ((accept && (WAIT_CYCLES == 0)) ||
                          ((state == WAIT) && (wait_cnt == 4'd0)));

  assign cur_we     = (state == IDLE) ? req_we     : cap_we;
  assign cur_addr   = (state == IDLE) ? req_addr   : cap_addr;
  assign cur_wdata  = (state == IDLE) ? req_wdata  : cap_wdata;
  assign cur_dmtype = (state == IDLE) ? req_dmtype : cap_dmtype;

  always_comb begin
    byte_off     = cur_addr[1:0];
    word_idx     = cur_addr[AW+1:2];
    bad_type     = cur_dmtype > 3'd4;
    out_of_range = (cur_addr >> (AW + 2)) != 32'd0;
    case (cur_dmtype)
      3'd0:       misaligned = byte_off != 2'd0;
      3'd1, 3'd2: misaligned = byte_off[0];
      default:    misaligned = 1'b0;
    endcase
    fault = misaligned | out_of_range | bad_type;

    mem_word  = mem[word_idx];
    lane_data = mem_word >> {byte_off, 3'b000};
    case (cur_dmtype)
      3'd0:    load_data = lane_data;
      3'd1:    load_data = {{16{lane_data[15]}}, lane_data[15:0]};
      3'd2:    load_data = {16'h0000, lane_data[15:0]};
      3'd3:    load_data = {{24{lane_data[7]}}, lane_data[7:0]};
      3'd4:    load_data = {24'h000000, lane_data[7:0]};
      default: load_data = 32'd0;
    endcase

    case (cur_dmtype)
      3'd0:       lane_en = 4'b1111;
      3'd1, 3'd2: lane_en = 4'b0011 << byte_off;
      3'd3, 3'd4: lane_en = 4'b0001 << byte_off;
      default:    lane_en = 4'b0000;
    endcase
    store_data = cur_wdata << {byte_off, 3'b000};
    for (int i = 0; i < 4; i++) begin
      store_word[8*i +: 8] = lane_en[i] ? store_data[8*i +: 8] : mem_word[8*i +: 8];
    end
  end

  // Array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (commit && cur_we && !fault) begin
      mem[word_idx] <= store_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'd0;
      rsp_err    <= 1'b0;
      wait_cnt   <= 4'd0;
      cap_we     <= 1'b0;
      cap_addr   <= 32'd0;
      cap_wdata  <= 32'd0;
      cap_dmtype <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_we     <= req_we;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
            cap_dmtype <= req_dmtype;
            req_ready  <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state    <= WAIT;
              wait_cnt <= 4'(WAIT_CYCLES - 1);
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (commit) begin
        rsp_valid <= 1'b1;
        rsp_err   <= fault;
        rsp_rdata <= (fault || cur_we) ? 32'd0 : load_data;
      end
    end
  end

`ifdef DMEM_ERR_LATCH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_sticky <= 1'b0;
      err_addr   <= 32'd0;
    end else if (commit && fault && !err_sticky) begin
      err_sticky <= 1'b1;
      err_addr   <= cur_addr;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 3 wait states) against a byte-array model.
module tb_dmem_responder;
  localparam int DEPTH  = 1024;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_dmtype [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];
`ifdef DMEM_ERR_LATCH_EN
  logic        err_sticky [2];
  logic [31:0] err_addr   [2];
  logic        m_sticky   [2];
  logic [31:0] m_eaddr    [2];
`endif

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] mb [2][NBYTES];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(g * 3)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_dmtype (req_dmtype[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g])
`ifdef DMEM_ERR_LATCH_EN
      ,
      .err_sticky (err_sticky[g]),
      .err_addr   (err_addr[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Byte-addressed reference: an access touches n consecutive bytes, little-endian.
  task automatic model(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] dt,
                       output logic [31:0] rd, output logic err);
    int n;
    int base;
    logic [63:0] v;
    n   = (dt == 3'd0) ? 4 : (dt <= 3'd2) ? 2 : 1;
    err = (dt > 3'd4) || (addr % n != 0) || (addr >= NBYTES);
    rd  = 32'd0;
    if (err) begin
`ifdef DMEM_ERR_LATCH_EN
      if (!m_sticky[d]) begin
        m_sticky[d] = 1'b1;
        m_eaddr[d]  = addr;
      end
`endif
      return;
    end
    base = int'(addr);
    if (we) begin
      for (int i = 0; i < n; i++) mb[d][base + i] = wdata[8*i +: 8];
    end else begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v = v | (64'(mb[d][base + i]) << (8 * i));
      if ((dt == 3'd1 || dt == 3'd3) && v[8*n-1]) v = v - (64'd1 << (8 * n));
      rd = v[31:0];
    end
  endtask

  // Called at a negedge; returns at the negedge after the response pulse.
  task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] dt,
                        output logic [31:0] got);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          k;
    req_we[d]     = we;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_dmtype[d] = dt;
    req_valid[d]  = 1'b1;
    k = 0;
    while (!req_ready[d] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", req_ready[d], 1);
    @(posedge clk);
    model(d, we, addr, wdata, dt, exp_rd, exp_err);
    @(negedge clk);
    req_valid[d] = 1'b0;
    k = 0;
    while (!rsp_valid[d] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, d * 3);
    chk("rdata", rsp_rdata[d], exp_rd);
    chk("err", rsp_err[d], exp_err);
    chk("busy_in_resp", req_ready[d], 0);
    got = rsp_rdata[d];
`ifdef DMEM_ERR_LATCH_EN
    chk("err_sticky", err_sticky[d], m_sticky[d]);
    chk("err_addr", err_addr[d], m_eaddr[d]);
`endif
    @(negedge clk);
    chk("pulse_width", rsp_valid[d], 0);
    chk("ready_after", req_ready[d], 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] addr;
    logic        e_tmp;
    int          k;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NBYTES; i++) mb[d][i] = 8'h00;
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0;   req_dmtype[d] = '0;
`ifdef DMEM_ERR_LATCH_EN
      m_sticky[d] = 1'b0; m_eaddr[d] = '0;
`endif
    end

    rst = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", req_ready[d], 1);
      chk("rst_valid", rsp_valid[d], 0);
      chk("rst_rdata", rsp_rdata[d], 0);
      chk("rst_err", rsp_err[d], 0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd0, got);
    chk("st_rdata_zero", got, 32'h0);
    do_req(0, 1'b0, 32'h10, 32'h0, 3'd0, got);
    chk("ld_word", got, 32'hDEADBEEF);
    do_req(0, 1'b1, 32'h20, 32'h11223344, 3'd0, got);
    do_req(0, 1'b1, 32'h21, 32'h000000AA, 3'd3, got);
    do_req(0, 1'b0, 32'h20, 32'h0, 3'd0, got);
    chk("lane_byte_word", got, 32'h1122AA44);
    do_req(0, 1'b0, 32'h21, 32'h0, 3'd3, got);
    chk("lb_signed", got, 32'hFFFFFFAA);
    do_req(0, 1'b0, 32'h21, 32'h0, 3'd4, got);
    chk("lb_unsigned", got, 32'h000000AA);
    do_req(0, 1'b0, 32'h22, 32'h0, 3'd2, got);
    chk("lh_unsigned", got, 32'h00001122);

    do_req(0, 1'b1, 32'h12, 32'h0BADF00D, 3'd0, got);
    chk("mis_word_err", rsp_err[0], 1);
    do_req(0, 1'b0, 32'h16, 32'h0, 3'd0, got);
    do_req(0, 1'b1, 32'h13, 32'h0000BEEF, 3'd1, got);
    chk("mis_half_err", rsp_err[0], 1);
    chk("mis_half_rdata", rsp_rdata[0], 0);
    do_req(0, 1'b0, 32'h10, 32'h0, 3'd0, got);
    chk("mis_no_write", got, 32'hDEADBEEF);
`ifdef DMEM_ERR_LATCH_EN
    chk("latch_first_addr", err_addr[0], 32'h12);
    chk("latch_sticky", err_sticky[0], 1);
`endif
    do_req(0, 1'b0, 32'h00010000, 32'h0, 3'd0, got);
    chk("oor_err", rsp_err[0], 1);
    do_req(0, 1'b0, 32'h10, 32'h0, 3'd6, got);
    chk("undef_err", rsp_err[0], 1);
    do_req(0, 1'b1, NBYTES - 4, 32'hA5A5_5A5A, 3'd0, got);
    do_req(0, 1'b0, NBYTES - 2, 32'h0, 3'd1, got);
    chk("last_word_half", got, 32'hFFFFA5A5);

    // Held request during the busy window of the 3-wait-state instance.
    req_we[1] = 1'b1; req_addr[1] = 32'h40; req_wdata[1] = 32'h01020304; req_dmtype[1] = 3'd0;
    req_valid[1] = 1'b1;
    @(posedge clk);
    model(1, 1'b1, 32'h40, 32'h01020304, 3'd0, exp_a, e_tmp);
    @(negedge clk);
    req_we[1] = 1'b0; req_wdata[1] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_busy", req_ready[1], 0);
      if (i < 3) @(negedge clk);
    end
    chk("b2b_rsp_a", rsp_valid[1], 1);
    chk("b2b_rdata_a", rsp_rdata[1], exp_a);
    @(negedge clk);
    chk("b2b_ready", req_ready[1], 1);
    chk("b2b_idle_valid", rsp_valid[1], 0);
    @(posedge clk);
    model(1, 1'b0, 32'h40, 32'h0, 3'd0, exp_b, e_tmp);
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("b2b_accepted", req_ready[1], 0);
    k = 0;
    while (!rsp_valid[1] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_latency", k, 3);
    chk("b2b_rdata_b", rsp_rdata[1], exp_b);
    chk("b2b_value", rsp_rdata[1], 32'h01020304);
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        case ($urandom_range(0, 9))
          0:       addr = 32'h0001_0000 + $urandom_range(0, 255);
          1:       addr = NBYTES - 4 + $urandom_range(0, 3);
          2:       addr = NBYTES + $urandom_range(0, 3);
          default: addr = $urandom_range(0, 63);
        endcase
        do_req(d, 1'($urandom_range(0, 1)), addr, $urandom, 3'($urandom_range(0, 5)), got);
      end
    end

    // Reset while the 3-wait-state instance is counting down a byte store.
    do_req(1, 1'b1, 32'h30, 32'hCAFEF00D, 3'd0, got);
    do_req(1, 1'b0, 32'h30, 32'h0, 3'd0, got);
    req_we[1] = 1'b1; req_addr[1] = 32'h30; req_wdata[1] = 32'h55; req_dmtype[1] = 3'd3;
    req_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("rw_busy", req_ready[1], 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rw_ready", req_ready[1], 1);
    chk("rw_valid", rsp_valid[1], 0);
    chk("rw_rdata", rsp_rdata[1], 0);
    chk("rw_err", rsp_err[1], 0);
`ifdef DMEM_ERR_LATCH_EN
    for (int d = 0; d < 2; d++) begin
      chk("rst_sticky", err_sticky[d], 0);
      chk("rst_err_addr", err_addr[d], 0);
      m_sticky[d] = 1'b0;
      m_eaddr[d]  = '0;
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_req(1, 1'b0, 32'h30, 32'h0, 3'd0, got);
    chk("rw_old_data", got, 32'hCAFEF00D);
    do_req(0, 1'b0, 32'h20, 32'h0, 3'd0, got);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
